// File: rtl/axis_ofmap_tx_pkg.sv
// Shared types and constants for the ofmap AXI4-Stream transmitter.
// Optional feature macro: OFMAP_RELU_EN (clamp negative lanes to zero before saturation).
package axis_ofmap_tx_pkg;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int lanes_of(input int tdata_w);
        return tdata_w / 8;
    endfunction

endpackage

// File: rtl/axis_ofmap_tx_requant.sv
// One lane of requantization: rounding arithmetic shift, optional ReLU, int8 saturation.
// Optional feature macro: OFMAP_RELU_EN.
module ofmap_requant
    import axis_ofmap_tx_pkg::*;
#(
    parameter int ACC_WIDTH = 32
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    input  logic        [4:0]           i_shift,
    output logic        [7:0]           o_q
);

    // One extra bit keeps acc + rounding constant from overflowing.
    localparam int XW = ACC_WIDTH + 1;
    localparam logic signed [XW-1:0] ONE    = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] SAT_HI = XW'(INT8_MAX);
    localparam logic signed [XW-1:0] SAT_LO = XW'(INT8_MIN);

    logic signed [XW-1:0] w_ext;
    logic signed [XW-1:0] w_rnd;
    logic signed [XW-1:0] w_sum;
    logic signed [XW-1:0] w_shr;
    logic signed [XW-1:0] w_clip;

    assign w_ext = {i_acc[ACC_WIDTH-1], i_acc};
    assign w_rnd = (i_shift == 5'd0) ? '0 : (ONE << (i_shift - 5'd1));
    assign w_sum = w_ext + w_rnd;
    assign w_shr = w_sum >>> i_shift;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_clip = w_shr;
`ifdef OFMAP_RELU_EN
        if (w_shr[XW-1]) w_clip = '0;
`endif
        o_q = w_clip[7:0];
        if (w_clip > SAT_HI)      o_q = SAT_HI[7:0];
        else if (w_clip < SAT_LO) o_q = SAT_LO[7:0];
    end

endmodule

// File: rtl/axis_ofmap_tx.sv
// AXI4-Stream ofmap transmitter: requantizes GEMM accumulator vectors to int8 and streams cfg_len beats with TLAST.
// Optional feature macro: OFMAP_RELU_EN (passed through to the per-lane requantizer).
module axis_ofmap_tx
    import axis_ofmap_tx_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int ACC_WIDTH            = 32,
    parameter int LEN_W                = 16
) (
    input  logic                                          M_AXIS_ACLK,
    input  logic                                          M_AXIS_ARESETN,
    input  logic                                          start,
    input  logic [LEN_W-1:0]                              cfg_len,
    input  logic [4:0]                                    cfg_shift,
    output logic                                          busy,
    output logic                                          done,
    input  logic                                          res_valid,
    output logic                                          res_ready,
    input  logic [C_M_AXIS_TDATA_WIDTH/8*ACC_WIDTH-1:0]   res_data,
    output logic                                          M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]               M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]             M_AXIS_TSTRB,
    output logic                                          M_AXIS_TLAST,
    input  logic                                          M_AXIS_TREADY
);

    localparam int LANES = lanes_of(C_M_AXIS_TDATA_WIDTH);

    state_e                            r_state;
    state_e                            w_state_nxt;
    logic [LEN_W-1:0]                  r_len;
    logic [LEN_W-1:0]                  r_in_cnt;
    logic [LEN_W-1:0]                  r_out_cnt;
    logic [4:0]                        r_shift;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   r_mem [2];
    logic                              r_wr_ptr;
    logic                              r_rd_ptr;
    logic [1:0]                        r_fifo_cnt;

    logic                              w_start_ok;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_last_hs;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   w_q_vec;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            ofmap_requant #(
                .ACC_WIDTH (ACC_WIDTH)
            ) u_requant (
                .i_acc   (res_data[g*ACC_WIDTH +: ACC_WIDTH]),
                .i_shift (r_shift),
                .o_q     (w_q_vec[g*8 +: 8])
            );
        end
    endgenerate

    assign w_start_ok = start && (r_state == ST_IDLE) && (cfg_len != '0);
    assign w_push     = res_valid && res_ready;
    assign w_pop      = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_last_hs  = w_pop && M_AXIS_TLAST;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) r_state <= ST_IDLE;
        else                 r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last_hs)  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // res_ready depends only on registered state, never on TREADY.
    always_comb begin
        busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
        done      = (r_state == ST_DONE);
        res_ready = (r_state == ST_RUN) && (r_in_cnt != r_len) && (r_fifo_cnt != 2'd2);
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_len     <= '0;
            r_shift   <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_start_ok) begin
            r_len     <= cfg_len;
            r_shift   <= cfg_shift;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_push) r_in_cnt  <= r_in_cnt + LEN_W'(1);
            if (w_pop)  r_out_cnt <= r_out_cnt + LEN_W'(1);
        end
    end

    // NOTE: the two FIFO entries are reset so TDATA reads 0 out of reset rather than X.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_q_vec;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign M_AXIS_TVALID = (r_fifo_cnt != 2'd0);
    assign M_AXIS_TDATA  = r_mem[r_rd_ptr];
    assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){M_AXIS_TVALID}};
    assign M_AXIS_TLAST  = M_AXIS_TVALID && (r_out_cnt == r_len - LEN_W'(1));

endmodule
